// File: rtl/bcd_display_converter.sv
// Binary to packed 8-digit BCD (double dabble, one bit per cycle); done is WIDTH cycles after accept.
// Backpressure: in_ready is low while shifting and in_valid is ignored then. bcd/neg/overflow hold between completions.
module bcd_display_converter #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      bcd,
  output logic             neg,
  output logic             overflow,
  output logic             done
);

  localparam int CW            = $clog2(WIDTH + 1);
  localparam bit OVF_REACHABLE = (WIDTH >= 27);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [35:0]      scr_q, scr_d;
  logic             carry_q, carry_d;
  logic             sign_q, sign_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      bcd_q, bcd_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_bit;
  logic             in_sign;
  logic [WIDTH-1:0] in_mag;
  logic [35:0]      scr_adj;
  logic [35:0]      scr_shift;
  logic             carry_shift;
  logic             ovf_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == S_IDLE);
    accept   = in_ready && in_valid;
  end

  always_comb begin
    in_sign = SIGNED && in_value[WIDTH-1];
    // The unsigned reading of the WIDTH-bit negate is exact, so the most
    // negative input maps to 2^(WIDTH-1) without needing an extra bit.
    in_mag  = in_sign ? -in_value : in_value;

    scr_adj = scr_q;
    for (int i = 0; i < 9; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
    {carry_shift, scr_shift} = {scr_adj, bin_q[WIDTH-1]};

    last_bit = (cnt_q == CW'(1));
    // A bit leaving the 9th digit is sticky: the value can only grow from here.
    ovf_now  = OVF_REACHABLE && (carry_q || carry_shift || (scr_shift[35:32] != 4'd0));
  end

  always_comb begin
    bin_d   = bin_q;
    scr_d   = scr_q;
    carry_d = carry_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    if (accept) begin
      bin_d   = in_mag;
      scr_d   = '0;
      carry_d = 1'b0;
      sign_d  = in_sign;
      cnt_d   = CW'(WIDTH);
    end else if (state_q == S_SHIFT) begin
      bin_d   = bin_q << 1;
      scr_d   = scr_shift;
      carry_d = carry_q | carry_shift;
      cnt_d   = cnt_q - CW'(1);
      if (last_bit) begin
        bcd_d  = ovf_now ? 32'h9999_9999 : scr_shift[31:0];
        neg_d  = sign_q;
        ovf_d  = ovf_now;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      scr_q   <= '0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      carry_q <= carry_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bcd      = bcd_q;
  assign neg      = neg_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_bcd_display_converter.sv
// Directed bench: unsigned 16-bit, signed 16-bit and unsigned 32-bit converters on one clock.
module tb_bcd_display_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [15:0] a_val;  logic a_vld, a_rdy, a_neg, a_ovf, a_done;  logic [31:0] a_bcd;
  logic [15:0] b_val;  logic b_vld, b_rdy, b_neg, b_ovf, b_done;  logic [31:0] b_bcd;
  logic [31:0] c_val;  logic c_vld, c_rdy, c_neg, c_ovf, c_done;  logic [31:0] c_bcd;

  bcd_display_converter #(.WIDTH(16), .SIGNED(1'b0)) u_a (
    .clk(clk), .rst(rst), .in_value(a_val), .in_valid(a_vld), .in_ready(a_rdy),
    .bcd(a_bcd), .neg(a_neg), .overflow(a_ovf), .done(a_done));

  bcd_display_converter #(.WIDTH(16), .SIGNED(1'b1)) u_b (
    .clk(clk), .rst(rst), .in_value(b_val), .in_valid(b_vld), .in_ready(b_rdy),
    .bcd(b_bcd), .neg(b_neg), .overflow(b_ovf), .done(b_done));

  bcd_display_converter #(.WIDTH(32), .SIGNED(1'b0)) u_c (
    .clk(clk), .rst(rst), .in_value(c_val), .in_valid(c_vld), .in_ready(c_rdy),
    .bcd(c_bcd), .neg(c_neg), .overflow(c_ovf), .done(c_done));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int sel, input logic vld, input logic [31:0] val);
    case (sel)
      0:       begin a_vld = vld; a_val = val[15:0]; end
      1:       begin b_vld = vld; b_val = val[15:0]; end
      default: begin c_vld = vld; c_val = val;       end
    endcase
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  // Accept one value, then wait (bounded) for done; lat counts edges after the accept edge.
  task automatic convert(input int sel, input logic [31:0] val, output int lat);
    set_in(sel, 1'b1, val);
    step();
    set_in(sel, 1'b0, val);
    lat = 0;
    while (!done_of(sel) && lat < 100) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busy_bad;
    int stable_bad;
    int spur;
    logic [31:0] prev;

    rst = 1'b1;
    set_in(0, 1'b0, 32'h0);
    set_in(1, 1'b0, 32'h0);
    set_in(2, 1'b0, 32'h0);
    step();
    step();
    rst = 1'b0;

    chk("reset_ready", a_rdy, 1'b1);
    chk("reset_bcd",   a_bcd, 32'h0);
    chk("reset_done",  a_done, 1'b0);
    chk("reset_neg",   b_neg, 1'b0);
    chk("reset_ovf",   c_ovf, 1'b0);

    // 0xFFFF: busy for exactly 16 cycles after the accept edge
    set_in(0, 1'b1, 32'hFFFF);
    step();
    set_in(0, 1'b0, 32'h0);
    busy_bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (a_rdy !== 1'b0 || a_done !== 1'b0) busy_bad++;
      step();
    end
    chk("ffff_busy",  busy_bad, 0);
    chk("ffff_done",  a_done, 1'b1);
    chk("ffff_ready", a_rdy, 1'b1);
    chk("ffff_bcd",   a_bcd, 32'h0006_5535);
    chk("ffff_ovf",   a_ovf, 1'b0);
    chk("ffff_neg",   a_neg, 1'b0);
    step();
    chk("ffff_done_pulse", a_done, 1'b0);

    convert(1, 32'hFB2E, lat);
    chk("s_m1234_lat", lat, 16);
    chk("s_m1234_bcd", b_bcd, 32'h0000_1234);
    chk("s_m1234_neg", b_neg, 1'b1);
    convert(1, 32'h8000, lat);
    chk("s_min_bcd", b_bcd, 32'h0003_2768);
    chk("s_min_neg", b_neg, 1'b1);
    convert(1, 32'h0000, lat);
    chk("s_zero_bcd", b_bcd, 32'h0);
    chk("s_zero_neg", b_neg, 1'b0);

    convert(2, 32'h05F5_E0FF, lat);
    chk("w32_max_lat", lat, 32);
    chk("w32_max_bcd", c_bcd, 32'h9999_9999);
    chk("w32_max_ovf", c_ovf, 1'b0);
    convert(2, 32'hFFFF_FFFF, lat);
    chk("w32_ovf_bcd", c_bcd, 32'h9999_9999);
    chk("w32_ovf_ovf", c_ovf, 1'b1);
    convert(2, 32'h0, lat);
    chk("w32_zero_bcd", c_bcd, 32'h0);
    chk("w32_zero_ovf", c_ovf, 1'b0);

    // in_valid held high: one accept per 17 cycles, results alternate 42/7
    prev = a_bcd;
    stable_bad = 0;
    set_in(0, 1'b1, 32'd42);
    step();
    for (int it = 0; it < 4; it++) begin
      set_in(0, 1'b1, (it % 2 == 0) ? 32'd7 : 32'd42);
      chk("stream_busy", a_rdy, 1'b0);
      lat = 0;
      while (!a_done && lat < 100) begin
        if (a_bcd !== prev) stable_bad++;
        step();
        lat++;
      end
      chk("stream_lat", lat, 16);
      chk("stream_bcd", a_bcd, (it % 2 == 0) ? 32'h42 : 32'h7);
      prev = a_bcd;
      step();
    end
    set_in(0, 1'b0, 32'h0);
    lat = 0;
    while (!a_done && lat < 100) begin
      if (a_bcd !== prev) stable_bad++;
      step();
      lat++;
    end
    chk("stream_tail_bcd", a_bcd, 32'h42);
    chk("stream_stable", stable_bad, 0);
    step();

    // Reset five cycles into a conversion discards it
    set_in(0, 1'b1, 32'd9999);
    step();
    set_in(0, 1'b0, 32'h0);
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_ready", a_rdy, 1'b1);
    chk("abort_bcd",   a_bcd, 32'h0);
    chk("abort_done",  a_done, 1'b0);
    spur = 0;
    repeat (40) begin
      if (a_done) spur++;
      step();
    end
    chk("abort_no_done", spur, 0);
    convert(0, 32'd9999, lat);
    chk("after_abort_lat", lat, 16);
    chk("after_abort_bcd", a_bcd, 32'h0000_9999);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_display_converter.md
Name: bcd_display_converter

Overview:
- Sequential binary-to-packed-BCD converter using shift-and-add-3 (double dabble), one bit per cycle.
- Sits directly upstream of the 8-digit seven-segment driver. Its 32-bit bcd output (8 nibbles, digit 0 in [3:0]) drives the driver's value input, so the board shows CPU values in decimal rather than hex.
- bcd is held stable between conversions so the multiplexed display never shows partial results.

Parameters:
- WIDTH, 16, bit width of in_value; legal range 1..32.
- SIGNED, 0, 1 = in_value is two's complement: magnitude is converted and the sign is reported on neg. 0 = unsigned.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_value  input  WIDTH  binary value to convert; sampled only on the accept edge.
- in_valid  input  1  request a conversion of in_value.
- in_ready  output  1  high when idle; a conversion is accepted on an edge where in_valid && in_ready.
- bcd  output  32  packed BCD result, 8 digits; holds the last completed result.
- neg  output  1  sign of the last completed result; always 0 when SIGNED=0.
- overflow  output  1  last result exceeded 99,999,999.
- done  output  1  one-cycle pulse; bcd, neg and overflow are newly valid in this cycle.

Behaviour:
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0.
- Reset (any state, including mid-SHIFT):
  - State goes to IDLE; the in-flight conversion is discarded.
  - bcd=0, neg=0, overflow=0, done=0.
  - Iteration counter and scratch registers are cleared.
- Accept edge (IDLE, in_valid=1):
  - Latch the magnitude into the binary shift register.
    - SIGNED=1 and in_value MSB set: magnitude = two's-complement negate, computed in WIDTH+1 bits so the most negative value is handled. Example: WIDTH=16, 0x8000 gives 32768.
    - Otherwise the magnitude is in_value.
  - Latch the sign internally; clear the BCD scratch (9 nibbles: 8 output digits + 1 overflow digit).
  - Counter = WIDTH; go to SHIFT.
- Each edge in SHIFT:
  - Every scratch nibble >= 5 gets +3.
  - Then {scratch, binary} shifts left by 1.
  - Counter decrements.
  - When the edge processes the last bit (counter == 1):
    - Go to IDLE.
    - Register bcd, neg and overflow from the post-step result.
    - Assert done for the following cycle.
- Latency and throughput:
  - done is high in the cycle after the WIDTH-th edge following the accept edge (WIDTH cycles of latency).
  - in_ready is high in that same cycle, so a back-to-back accept is allowed: one conversion per WIDTH+1 cycles.
- Overflow:
  - overflow=1 when the 9th scratch nibble, or any carry beyond it, is nonzero.
  - On overflow, bcd saturates to 0x99999999.
  - Overflow is only reachable for WIDTH >= 27; for smaller WIDTH it must remain constant 0.
- Signed edge cases:
  - Negative zero cannot occur.
  - A SIGNED=1 input of 0 gives neg=0.
- Input timing:
  - in_valid is ignored while in SHIFT; no queuing.
  - in_value changes after the accept edge have no effect.
- Output stability: bcd, neg and overflow change only on a completion edge or on reset; they are otherwise constant.
- done: never high for more than one consecutive cycle.

Test Plan:
- Reset, WIDTH=16, SIGNED=0, in_value=0xFFFF with in_valid held one cycle:
  - in_ready low for 16 cycles.
  - done pulses exactly 16 cycles after the accept edge.
  - bcd=0x00065535, overflow=0, neg=0.
- WIDTH=16, SIGNED=1, in_value=0xFB2E (-1234) -> bcd=0x00001234, neg=1.
- Then in_value=0x8000 -> bcd=0x00032768, neg=1.
- WIDTH=32:
  - in_value=0x05F5E0FF (99,999,999) -> bcd=0x99999999, overflow=0.
  - Then 0xFFFFFFFF -> bcd=0x99999999, overflow=1.
  - Then 0 -> bcd=0x00000000, overflow=0.
- in_valid held high continuously with alternating values 42/7 (WIDTH=16):
  - Accepts occur every 17 cycles.
  - Results 0x00000042 and 0x00000007 alternate.
  - bcd is stable between done pulses.
  - Pulses of in_valid during SHIFT are not accepted.
- Assert rst for one cycle 5 cycles into a conversion of 9999:
  - Next cycle: in_ready=1, bcd=0, done=0.
  - No done pulse follows.
  - A new conversion of 9999 then yields 0x00009999.
